// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - register-file write port and scoreboard clear bundle
// master drives the write/clear strobes, slave (the register file) returns regWriteDone.
interface regfile_write_arbiter_if;
  logic [4:0]  regWriteAddr;
  logic [63:0] regWriteData;
  logic        regWriteEn;
  logic        regWriteDone;
  logic [4:0]  regClearAddr;
  logic        regClearEn;

  modport master (
    output regWriteAddr, regWriteData, regWriteEn, regClearAddr, regClearEn,
    input  regWriteDone
  );

  modport slave (
    input  regWriteAddr, regWriteData, regWriteEn, regClearAddr, regClearEn,
    output regWriteDone
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing the register-file write port
// Optional watchdog on the WRITE wait enabled by defining WB_ARB_WATCHDOG_EN.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [5*NUM_REQ-1:0]    req_addr,
  input  logic [64*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_done,
  regfile_write_arbiter_if.master rf,
  output logic                    busy,
  output logic [31:0]             write_count,
  output logic                    wb_timeout
);
  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  state_t             state, state_n;
  logic [IW-1:0]      rr_ptr, rr_ptr_n, idx, idx_n, grant_idx;
  logic               grant_found;
  logic [NUM_REQ-1:0] mask, mask_n, eligible, done_n;
  logic [4:0]         addr_q, addr_n;
  logic [63:0]        data_q, data_n;
  logic [31:0]        count_n;
  logic               timeout_n;
  logic               wd_expired;

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] p);
    return IW'((int'(p) + 1) % NUM_REQ);
  endfunction

`ifdef WB_ARB_WATCHDOG_EN
  logic [31:0] wd_cnt;

  // Held at zero outside WRITE, so it restarts on every entry to WRITE.
  always_ff @(posedge clk) begin
    if (reset || state != WRITE) wd_cnt <= '0;
    else                         wd_cnt <= wd_cnt + 32'd1;
  end

  assign wd_expired = (state == WRITE) && !rf.regWriteDone && (wd_cnt == 32'(TIMEOUT - 1));
`else
  // No watchdog: WRITE waits for regWriteDone indefinitely.
  assign wd_expired = (TIMEOUT < 0);
`endif

  always_comb begin
    eligible    = req_valid & ~mask;
    grant_found = 1'b0;
    grant_idx   = '0;
    // Descending scan so the lowest offset from rr_ptr wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eligible[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = IW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_n   = state;
    rr_ptr_n  = rr_ptr;
    idx_n     = idx;
    addr_n    = addr_q;
    data_n    = data_q;
    done_n    = '0;
    count_n   = write_count;
    timeout_n = wb_timeout;
    // Mask survives the req_done cycle and covers exactly one IDLE cycle after it.
    if (|req_done)          mask_n = mask;
    else if (state == IDLE) mask_n = '0;
    else                    mask_n = mask;

    case (state)
      IDLE: begin
        if (grant_found) begin
          idx_n  = grant_idx;
          addr_n = req_addr[5*int'(grant_idx) +: 5];
          data_n = req_data[64*int'(grant_idx) +: 64];
          if (addr_n == 5'd0) begin
            done_n[grant_idx] = 1'b1;
            mask_n            = '0;
            mask_n[grant_idx] = 1'b1;
            rr_ptr_n          = ptr_after(grant_idx);
          end else begin
            state_n = WRITE;
          end
        end
      end
      WRITE: begin
        if (rf.regWriteDone || wd_expired) begin
          state_n     = CLEAR;
          done_n[idx] = 1'b1;
          mask_n      = '0;
          mask_n[idx] = 1'b1;
          if (rf.regWriteDone) count_n   = write_count + 32'd1;
          else                 timeout_n = 1'b1;
        end
      end
      CLEAR: begin
        state_n  = IDLE;
        rr_ptr_n = ptr_after(idx);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      idx             <= '0;
      mask            <= '0;
      addr_q          <= '0;
      data_q          <= '0;
      req_done        <= '0;
      busy            <= 1'b0;
      write_count     <= '0;
      wb_timeout      <= 1'b0;
      rf.regWriteEn   <= 1'b0;
      rf.regWriteAddr <= '0;
      rf.regWriteData <= '0;
      rf.regClearEn   <= 1'b0;
      rf.regClearAddr <= '0;
    end else begin
      state           <= state_n;
      rr_ptr          <= rr_ptr_n;
      idx             <= idx_n;
      mask            <= mask_n;
      addr_q          <= addr_n;
      data_q          <= data_n;
      req_done        <= done_n;
      busy            <= (state_n != IDLE);
      write_count     <= count_n;
      wb_timeout      <= timeout_n;
      rf.regWriteEn   <= (state_n == WRITE);
      rf.regWriteAddr <= (state_n == WRITE) ? addr_n : 5'd0;
      rf.regWriteData <= (state_n == WRITE) ? data_n : 64'd0;
      rf.regClearEn   <= (state_n == CLEAR);
      rf.regClearAddr <= (state_n == CLEAR) ? addr_n : 5'd0;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed bench for regfile_write_arbiter (NUM_REQ=2)
// Define WB_ARB_WATCHDOG_EN to build with TIMEOUT=4 and run the watchdog case.
module tb_regfile_write_arbiter;
`ifdef WB_ARB_WATCHDOG_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 64;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [9:0]   req_addr;
  logic [127:0] req_data;
  logic [1:0]   req_done;
  logic         busy;
  logic [31:0]  write_count;
  logic         wb_timeout;

  int checks = 0;
  int errors = 0;

  int exp_addr [12] = '{0, 3, 0, 0, 7, 0, 0, 3, 0, 0, 7, 0};
  int exp_done [12] = '{0, 0, 1, 0, 0, 2, 0, 0, 1, 0, 0, 2};

  regfile_write_arbiter_if rf_bus ();

  regfile_write_arbiter #(.NUM_REQ(2), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_done    (req_done),
    .rf          (rf_bus),
    .busy        (busy),
    .write_count (write_count),
    .wb_timeout  (wb_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    rf_bus.regWriteDone = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    req_addr = '0;
    req_data = '0;
    rf_bus.regWriteDone = 1'b0;
    tick();
    tick();
    check("rst_we", rf_bus.regWriteEn, 0);
    check("rst_waddr", rf_bus.regWriteAddr, 0);
    check("rst_ce", rf_bus.regClearEn, 0);
    check("rst_done", req_done, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", write_count, 0);
    check("rst_to", wb_timeout, 0);
    reset = 1'b0;

    // Single write, done on the first regWriteEn cycle.
    req_valid = 2'b01; req_addr[4:0] = 5'd5; req_data[63:0] = 64'hDEAD;
    tick();
    check("t1_we", rf_bus.regWriteEn, 1);
    check("t1_waddr", rf_bus.regWriteAddr, 5);
    check("t1_wdata", rf_bus.regWriteData, 64'hDEAD);
    check("t1_busy", busy, 1);
    check("t1_done_early", req_done, 0);
    rf_bus.regWriteDone = 1'b1;
    tick();
    check("t1_we_off", rf_bus.regWriteEn, 0);
    check("t1_wdata_off", rf_bus.regWriteData, 0);
    check("t1_ce", rf_bus.regClearEn, 1);
    check("t1_caddr", rf_bus.regClearAddr, 5);
    check("t1_done", req_done, 2'b01);
    check("t1_cnt", write_count, 1);
    rf_bus.regWriteDone = 1'b0; req_valid = 2'b00;
    tick();
    check("t1_ce_off", rf_bus.regClearEn, 0);
    check("t1_done_off", req_done, 0);
    check("t1_idle", busy, 0);

    // Contention with both requesters held valid and immediate done.
    do_reset();
    req_valid = 2'b11;
    req_addr = {5'd7, 5'd3};
    req_data = {64'h77, 64'h33};
    rf_bus.regWriteDone = 1'b1;
    for (int i = 1; i < 12; i++) begin
      tick();
      check($sformatf("t2_we_%0d", i), rf_bus.regWriteEn, (exp_addr[i] != 0) ? 1 : 0);
      check($sformatf("t2_waddr_%0d", i), rf_bus.regWriteAddr, 64'(exp_addr[i]));
      check($sformatf("t2_wdata_%0d", i), rf_bus.regWriteData,
            (exp_addr[i] == 3) ? 64'h33 : (exp_addr[i] == 7) ? 64'h77 : 64'h0);
      check($sformatf("t2_done_%0d", i), req_done, 64'(exp_done[i]));
    end
    check("t2_cnt", write_count, 4);
    req_valid = 2'b00; rf_bus.regWriteDone = 1'b0;

    // Write to x0: retired without touching the port.
    do_reset();
    req_valid = 2'b01; req_addr = '0; req_data = 128'h1;
    tick();
    check("t3_done", req_done, 2'b01);
    check("t3_we", rf_bus.regWriteEn, 0);
    check("t3_ce", rf_bus.regClearEn, 0);
    check("t3_busy", busy, 0);
    req_valid = 2'b00;
    tick();
    check("t3_done_off", req_done, 0);
    check("t3_we2", rf_bus.regWriteEn, 0);
    check("t3_cnt", write_count, 0);

`ifndef WB_ARB_WATCHDOG_EN
    // Stalled register file: write held stable until done.
    do_reset();
    req_valid = 2'b10; req_addr = {5'd9, 5'd0}; req_data = {64'h1234_5678_9ABC_DEF0, 64'h0};
    for (int i = 1; i <= 11; i++) begin
      tick();
      check($sformatf("t4_we_%0d", i), rf_bus.regWriteEn, 1);
      check($sformatf("t4_waddr_%0d", i), rf_bus.regWriteAddr, 9);
      check($sformatf("t4_wdata_%0d", i), rf_bus.regWriteData, 64'h1234_5678_9ABC_DEF0);
      check($sformatf("t4_ce_%0d", i), rf_bus.regClearEn, 0);
    end
    rf_bus.regWriteDone = 1'b1;
    tick();
    check("t4_ce", rf_bus.regClearEn, 1);
    check("t4_caddr", rf_bus.regClearAddr, 9);
    check("t4_done", req_done, 2'b10);
    check("t4_we_off", rf_bus.regWriteEn, 0);
    check("t4_cnt", write_count, 1);
    check("t4_to", wb_timeout, 0);
    req_valid = 2'b00; rf_bus.regWriteDone = 1'b0;
`endif

    // Reset in WRITE while requester 1 holds the port; rr_ptr returns to 0.
    do_reset();
    req_valid = 2'b01; req_addr = {5'd6, 5'd4}; req_data = {64'h66, 64'h44};
    rf_bus.regWriteDone = 1'b1;
    tick();
    tick();
    check("t5_pre_done", req_done, 2'b01);
    req_valid = 2'b00; rf_bus.regWriteDone = 1'b0;
    tick();
    req_valid = 2'b11;
    tick();
    check("t5_we1", rf_bus.regWriteEn, 1);
    check("t5_waddr1", rf_bus.regWriteAddr, 6);
    reset = 1'b1;
    tick();
    check("t5_rst_we", rf_bus.regWriteEn, 0);
    check("t5_rst_waddr", rf_bus.regWriteAddr, 0);
    check("t5_rst_wdata", rf_bus.regWriteData, 0);
    check("t5_rst_ce", rf_bus.regClearEn, 0);
    check("t5_rst_done", req_done, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_cnt", write_count, 0);
    reset = 1'b0;
    tick();
    check("t5_regrant_we", rf_bus.regWriteEn, 1);
    check("t5_regrant_addr", rf_bus.regWriteAddr, 4);
    check("t5_regrant_done", req_done, 0);
    rf_bus.regWriteDone = 1'b1;
    tick();
    check("t5_done", req_done, 2'b01);
    check("t5_caddr", rf_bus.regClearAddr, 4);
    req_valid = 2'b00; rf_bus.regWriteDone = 1'b0;

`ifdef WB_ARB_WATCHDOG_EN
    // Watchdog: done never arrives, CLEAR forced after TIMEOUT WRITE cycles.
    do_reset();
    req_valid = 2'b01; req_addr = {5'd0, 5'd8}; req_data = 128'h88;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("t6_we_%0d", i), rf_bus.regWriteEn, 1);
      check($sformatf("t6_to_%0d", i), wb_timeout, 0);
    end
    tick();
    check("t6_ce", rf_bus.regClearEn, 1);
    check("t6_caddr", rf_bus.regClearAddr, 8);
    check("t6_done", req_done, 2'b01);
    check("t6_to", wb_timeout, 1);
    check("t6_cnt", write_count, 0);
    req_valid = 2'b00;
    tick();
    tick();
    check("t6_to_sticky", wb_timeout, 1);
    check("t6_idle", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
